// File: rtl/int_sync_crossing_sink.sv
// -----------------------------------------------------------------------------
// int_sync_crossing_sink
//
// Receive-side stage of an interrupt clock-domain crossing. The source side
// launches a registered interrupt level vector from a foreign clock domain.
// This block brings every bit into the local clock domain through its own
// SYNC_DEPTH flop chain. It then presents the synchronised level and a sticky
// per-bit rising-edge pending flag that software can clear.
//
// Optional feature (compile-time macro INT_SYNC_SINK_FILTER_EN):
//   A per-bit glitch filter sits between the synchroniser and auto_out. A new
//   level is passed on only after it has been stable for FILTER_CYCLES cycles.
//   When the macro is undefined, auto_out is wired directly to the last
//   synchroniser stage.
//
// Parameters
//   WIDTH          number of interrupt lines (1..32)
//   SYNC_DEPTH     synchroniser stages per bit (2..8)
//   FILTER_CYCLES  glitch-filter stability window in cycles (1..255)
//
// Ports
//   clock          local clock; all logic runs on the rising edge
//   reset          synchronous, active-high
//   auto_in_sync   interrupt levels from the source crossing (async to clock)
//   auto_out       synchronised (optionally filtered) interrupt levels
//   pending        sticky rising-edge flags, one per line
//   clear          per-bit pending clear, sampled every cycle
//   any_pending    OR of all pending flags, same cycle as pending
// -----------------------------------------------------------------------------
module int_sync_crossing_sink #(
    parameter int WIDTH         = 1,
    parameter int SYNC_DEPTH    = 3,
    parameter int FILTER_CYCLES = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] auto_in_sync,
    output logic [WIDTH-1:0] auto_out,
    output logic [WIDTH-1:0] pending,
    input  logic [WIDTH-1:0] clear,
    output logic             any_pending
);

    // -------------------------------------------------------------------------
    // Elaboration-time parameter checks
    // -------------------------------------------------------------------------
    if (SYNC_DEPTH < 2 || SYNC_DEPTH > 8) begin : g_bad_sync_depth
        $error("int_sync_crossing_sink: SYNC_DEPTH must be in 2..8");
    end
    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $error("int_sync_crossing_sink: WIDTH must be in 1..32");
    end
    if (FILTER_CYCLES < 1 || FILTER_CYCLES > 255) begin : g_bad_filter
        $error("int_sync_crossing_sink: FILTER_CYCLES must be in 1..255");
    end

    // -------------------------------------------------------------------------
    // Synchroniser chain
    // -------------------------------------------------------------------------
    // Plain flop-to-flop chain with no logic between the stages, so the
    // metastability settling time is as long as possible. Each bit is
    // independent. A multi-bit change can therefore arrive skewed by a cycle
    // across bits.
    logic [WIDTH-1:0] stage [SYNC_DEPTH];
    logic [WIDTH-1:0] sync;

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int k = 0; k < SYNC_DEPTH; k++) begin
                stage[k] <= '0;
            end
        end else begin
            stage[0] <= auto_in_sync;
            for (int k = 1; k < SYNC_DEPTH; k++) begin
                stage[k] <= stage[k-1];
            end
        end
    end

    assign sync = stage[SYNC_DEPTH-1];

    // -------------------------------------------------------------------------
    // Optional glitch filter
    // -------------------------------------------------------------------------
`ifdef INT_SYNC_SINK_FILTER_EN
    localparam int CW = $clog2(FILTER_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_CYCLES - 1);

    logic [CW-1:0]    cnt [WIDTH];
    logic [WIDTH-1:0] filt_q;

    // The counter advances only while sync disagrees with the output. It
    // returns to 0 either on agreement or on the update itself. The largest
    // value it can reach is therefore FILTER_CYCLES-1. It never wraps, so no
    // saturation logic is needed.
    always_ff @(posedge clock) begin
        if (reset) begin
            filt_q <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (sync[i] == filt_q[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    filt_q[i] <= sync[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    assign auto_out = filt_q;
`else
    assign auto_out = sync;
`endif

    // -------------------------------------------------------------------------
    // Rising-edge detect and sticky pending flags
    // -------------------------------------------------------------------------
    // auto_out_q resets to 0. A line that is held high through reset is seen
    // as a fresh rise once it emerges from the synchroniser.
    logic [WIDTH-1:0] auto_out_q;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] pending_q;

    assign rise = auto_out & ~auto_out_q;

    // A set takes priority over a clear in the same cycle, so that a new
    // interrupt is never dropped. A falling level leaves the flag unchanged.
    always_ff @(posedge clock) begin
        if (reset) begin
            auto_out_q <= '0;
            pending_q  <= '0;
        end else begin
            auto_out_q <= auto_out;
            pending_q  <= rise | (pending_q & ~clear);
        end
    end

    assign pending     = pending_q;
    assign any_pending = |pending_q;

endmodule

// File: tb/tb_int_sync_crossing_sink.sv
module tb_int_sync_crossing_sink;

    localparam int WIDTH      = 4;
    localparam int SYNC_DEPTH = 3;
`ifdef INT_SYNC_SINK_FILTER_EN
    localparam int FILT = 4;
`else
    localparam int FILT = 0;
`endif
    localparam int LAT = SYNC_DEPTH + FILT;

    logic             clock;
    logic             reset;
    logic [WIDTH-1:0] auto_in_sync;
    logic [WIDTH-1:0] auto_out;
    logic [WIDTH-1:0] pending;
    logic [WIDTH-1:0] clear;
    logic             any_pending;

    int total;
    int bad;

    int_sync_crossing_sink #(
        .WIDTH        (WIDTH),
        .SYNC_DEPTH   (SYNC_DEPTH),
        .FILTER_CYCLES(4)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .auto_in_sync(auto_in_sync),
        .auto_out    (auto_out),
        .pending     (pending),
        .clear       (clear),
        .any_pending (any_pending)
    );

    // clock
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance n rising edges, then settle 1 time unit past the edge.
    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [WIDTH-1:0] obs,
                         input logic [WIDTH-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    initial begin
        total        = 0;
        bad          = 0;
        reset        = 1'b1;
        auto_in_sync = 4'b1111;
        clear        = 4'b0000;

        // Reset held with all inputs high: all outputs stay at zero.
        for (int i = 0; i < 5; i++) begin
            step(1);
            check("rst_out",  auto_out, 4'b0000);
            check("rst_pend", pending,  4'b0000);
            check("rst_any",  {3'b000, any_pending}, 4'b0000);
        end

        // Release with the lines still high: one rise after the chain fills.
        reset = 1'b0;
        step(LAT - 1);
        check("rel_out_early", auto_out, 4'b0000);
        step(1);
        check("rel_out",      auto_out, 4'b1111);
        check("rel_pend_lag", pending,  4'b0000);
        step(1);
        check("rel_pend", pending, 4'b1111);
        check("rel_any",  {3'b000, any_pending}, 4'b0001);
        clear = 4'b1111;
        step(1);
        clear = 4'b0000;
        check("clr_all_pend", pending, 4'b0000);
        check("clr_all_any",  {3'b000, any_pending}, 4'b0000);

        // A falling level must not set pending.
        auto_in_sync = 4'b0000;
        step(LAT);
        check("fall_all_out",  auto_out, 4'b0000);
        check("fall_all_pend", pending,  4'b0000);
        step(2);

        // Latency: 0 -> 0101
        auto_in_sync = 4'b0101;
        step(LAT - 1);
        check("lat_out_early", auto_out, 4'b0000);
        step(1);
        check("lat_out",      auto_out, 4'b0101);
        check("lat_pend_lag", pending,  4'b0000);
        step(1);
        check("lat_pend", pending, 4'b0101);
        check("lat_any",  {3'b000, any_pending}, 4'b0001);

        // Falling edge on bit 2 leaves pending unchanged.
        auto_in_sync = 4'b0001;
        step(LAT - 1);
        check("fall2_out_early", auto_out, 4'b0101);
        step(1);
        check("fall2_out",  auto_out, 4'b0001);
        check("fall2_pend", pending,  4'b0101);
        clear = 4'b0100;
        step(1);
        clear = 4'b0000;
        check("clr2_pend", pending, 4'b0001);

        // Set wins over a simultaneous clear.
        auto_in_sync = 4'b0000;
        step(LAT);
        check("svc_low_out",  auto_out, 4'b0000);
        check("svc_low_pend", pending,  4'b0001);
        auto_in_sync = 4'b0001;
        step(LAT);
        check("svc_rise_out", auto_out, 4'b0001);
        clear = 4'b0001;
        step(1);
        check("svc_set_wins", pending, 4'b0001);
        step(1);
        check("svc_clr_pend", pending, 4'b0000);
        check("svc_clr_any",  {3'b000, any_pending}, 4'b0000);
        clear = 4'b0000;

        // Mid-flight reset flushes the chain.
        auto_in_sync = 4'b0010;
        step(1);
        reset = 1'b1;
        step(1);
        check("mid_rst_out",  auto_out, 4'b0000);
        check("mid_rst_pend", pending,  4'b0000);
        step(2);
        check("mid_rst_out2", auto_out, 4'b0000);
        reset = 1'b0;
        step(LAT);
        check("mid_rel_out",  auto_out, 4'b0010);
        check("mid_rel_pend", pending,  4'b0000);
        step(1);
        check("mid_rel_pend2", pending, 4'b0010);
        check("mid_rel_any",   {3'b000, any_pending}, 4'b0001);

`ifdef INT_SYNC_SINK_FILTER_EN
        // Quiesce, then exercise the glitch filter.
        auto_in_sync = 4'b0000;
        clear        = 4'b1111;
        step(LAT + 2);
        clear = 4'b0000;
        check("flt_idle_out",  auto_out, 4'b0000);
        check("flt_idle_pend", pending,  4'b0000);

        // A 3-cycle pulse is filtered out.
        auto_in_sync = 4'b0001;
        step(3);
        auto_in_sync = 4'b0000;
        step(12);
        check("flt_short_out",  auto_out, 4'b0000);
        check("flt_short_pend", pending,  4'b0000);

        // A 6-cycle level gets through, 7 cycles after the input edge.
        auto_in_sync = 4'b0001;
        step(6);
        check("flt_long_early", auto_out, 4'b0000);
        auto_in_sync = 4'b0000;
        step(1);
        check("flt_long_out", auto_out, 4'b0001);
        step(1);
        check("flt_long_pend", pending, 4'b0001);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
